// File: rtl/pipelined_csa_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_csa_adder
//  Purpose  : Two-stage carry-select adder/subtractor with valid/ready flow
//             control. Stage 1 precomputes per-segment sums for both carry-ins;
//             stage 2 resolves the carry chain and registers the result.
//             Optional macro CSA_PIPE_OVF_EN enables the signed overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_csa_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_nseg = WIDTH / SEG;

    // ------------------------------------------------------------------
    // Operand conditioning and per-segment precompute
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]              w_b_eff;
    logic                          w_cin_eff;
    logic [SEG:0]                  w_lo;
    logic [c_nseg-1:1][SEG-1:0]    w_hi_sum0;
    logic [c_nseg-1:1][SEG-1:0]    w_hi_sum1;
    logic [c_nseg-1:1]             w_hi_c0;
    logic [c_nseg-1:1]             w_hi_c1;

    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
    assign w_lo      = {1'b0, a[SEG-1:0]} + {1'b0, w_b_eff[SEG-1:0]}
                     + {{SEG{1'b0}}, w_cin_eff};

    for (genvar k = 1; k < c_nseg; k++) begin : g_seg
        logic [SEG:0] w_s0;
        logic [SEG:0] w_s1;
        assign w_s0 = {1'b0, a[k*SEG +: SEG]} + {1'b0, w_b_eff[k*SEG +: SEG]};
        assign w_s1 = {1'b0, a[k*SEG +: SEG]} + {1'b0, w_b_eff[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, 1'b1};
        assign w_hi_sum0[k] = w_s0[SEG-1:0];
        assign w_hi_c0[k]   = w_s0[SEG];
        assign w_hi_sum1[k] = w_s1[SEG-1:0];
        assign w_hi_c1[k]   = w_s1[SEG];
    end

    // ------------------------------------------------------------------
    // Flow control: stage 1 may refill whenever it is empty or moving on
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_load;
    logic w_s1_take;

    assign w_s2_load = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_take = in_valid && in_ready;

    logic [SEG-1:0]             r_s1_lo_sum;
    logic                       r_s1_lo_c;
    logic [c_nseg-1:1][SEG-1:0] r_s1_hi_sum0;
    logic [c_nseg-1:1][SEG-1:0] r_s1_hi_sum1;
    logic [c_nseg-1:1]          r_s1_hi_c0;
    logic [c_nseg-1:1]          r_s1_hi_c1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_lo_sum  <= '0;
            r_s1_lo_c    <= 1'b0;
            r_s1_hi_sum0 <= '0;
            r_s1_hi_sum1 <= '0;
            r_s1_hi_c0   <= '0;
            r_s1_hi_c1   <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_take) begin
                r_s1_lo_sum  <= w_lo[SEG-1:0];
                r_s1_lo_c    <= w_lo[SEG];
                r_s1_hi_sum0 <= w_hi_sum0;
                r_s1_hi_sum1 <= w_hi_sum1;
                r_s1_hi_c0   <= w_hi_c0;
                r_s1_hi_c1   <= w_hi_c1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ripple the segment carries and select each segment pair
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    always_comb begin
        w_sum            = '0;
        w_cout           = r_s1_lo_c;
        w_sum[SEG-1:0]   = r_s1_lo_sum;
        for (int k = 1; k < c_nseg; k++) begin
            if (w_cout) begin
                w_sum[k*SEG +: SEG] = r_s1_hi_sum1[k];
                w_cout              = r_s1_hi_c1[k];
            end else begin
                w_sum[k*SEG +: SEG] = r_s1_hi_sum0[k];
                w_cout              = r_s1_hi_c0[k];
            end
        end
    end

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifdef CSA_PIPE_OVF_EN
    // Carry into the MSB is sum_msb ^ a_msb ^ b_msb, so only their XOR is kept.
    logic r_s1_msb_x;
    logic r_ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_msb_x <= 1'b0;
        end else if (w_s1_take) begin
            r_s1_msb_x <= a[WIDTH-1] ^ w_b_eff[WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_ovf <= w_sum[WIDTH-1] ^ r_s1_msb_x ^ w_cout;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csa_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_csa_adder
//  Purpose  : Scoreboard bench for pipelined_csa_adder (WIDTH=32, SEG=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_csa_adder;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
`ifdef CSA_PIPE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_csa_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference: plain integer arithmetic on the effective operation.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input logic ms);
        logic [63:0] u;
        longint      sv;
        exp_t        e;
        if (ms) begin
            u  = {32'd0, ma} + {32'd0, ~mb} + 64'd1;
            sv = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            u  = {32'd0, ma} + {32'd0, mb} + {63'd0, mc};
            sv = longint'($signed(ma)) + longint'($signed(mb)) + (mc ? 64'sd1 : 64'sd0);
        end
        e.s = u[WIDTH-1:0];
        e.c = u[WIDTH];
        e.o = OVF_ON && ((sv > MAXS) || (sv < MINS));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Output monitor: every presented result must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output actual=%0h required=none", sum);
            end else begin
                chk("mon_sum", sum, q[0].s);
                chk("mon_cout", cout, q[0].c);
                chk("mon_ovf", ovf, q[0].o);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Offer one beat; returns at the accept edge + 1.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc, input logic ts);
        int n = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                q.push_back(model(ta, tb_, tc, ts));
                break;
            end
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=%0d required<=1000", n);
                break;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                            input logic tc, input logic ts, input logic [WIDTH-1:0] es,
                            input logic ec, input logic eo);
        int n = 0;
        send(ta, tb_, tc, ts);
        while (!out_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e1;
        int   n;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        // Directed arithmetic cases
        directed("wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
        directed("sub_ovf", 32'h0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, OVF_ON);
        directed("seg_ripple", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

        // Backpressure: two beats fill the pipe, then in_ready must drop
        @(posedge clock); #1;
        out_ready = 1'b0;
        e1 = model(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        send(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        send(32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 1'b1);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum", sum, e1.s);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        chk("stall_drain_empty", q.size(), 0);

        // Reset with two beats in flight
        send(32'd100, 32'd200, 1'b0, 1'b0);
        send(32'd300, 32'd400, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum", sum, 0);
        q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("post_midrst_out_valid", out_valid, 0);
        end
        @(posedge clock); #1;

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clock);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("final_drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
